// File: rtl/snax_gemm_pkg.sv
// Shared types and constants for the SNAX GEMM operand reader.
// TCDM request/response structs default to a 64-bit data, 17-bit address interconnect.
package snax_gemm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    OUT   = 2'd2
  } reader_state_e;

  localparam int unsigned TcdmDataWidth  = 64;
  localparam int unsigned TcdmAddrWidth  = 17;
  localparam int unsigned TcdmByteOffset = TcdmDataWidth / 8;

  typedef struct packed {
    logic [TcdmAddrWidth-1:0]   addr;
    logic                       write;
    logic [3:0]                 amo;
    logic [TcdmDataWidth-1:0]   data;
    logic [TcdmDataWidth/8-1:0] strb;
    logic                       user;
  } tcdm_req_chan_t;

  typedef struct packed {
    tcdm_req_chan_t q;
    logic           q_valid;
  } tcdm_req_t;

  typedef struct packed {
    logic [TcdmDataWidth-1:0] data;
  } tcdm_rsp_chan_t;

  typedef struct packed {
    logic           q_ready;
    tcdm_rsp_chan_t p;
    logic           p_valid;
  } tcdm_rsp_t;

  // Byte distance between the words fetched by two adjacent ports.
  function automatic int unsigned byte_offset(input int unsigned data_width);
    return data_width / 8;
  endfunction

endpackage

// File: rtl/snax_gemm_port_slot.sv
// One TCDM read port: holds the request until granted, then captures the
// single response that follows and keeps it until the tile is consumed.
module snax_gemm_port_slot #(
  parameter int unsigned DataWidth = 64
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 launch,
  input  logic                 clear,
  input  logic                 q_ready,
  input  logic                 p_valid,
  input  logic [DataWidth-1:0] p_data,
  output logic                 q_valid,
  output logic                 complete,
  output logic [DataWidth-1:0] data
);

  logic                 q_valid_reg;
  logic                 issued_reg;
  logic                 have_reg;
  logic [DataWidth-1:0] data_reg;
  logic                 grant;
  logic                 capture;

  assign grant   = q_valid_reg & q_ready;
  // Only the response to our own outstanding grant is taken; stray p_valid is dropped.
  assign capture = issued_reg & ~have_reg & p_valid;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      q_valid_reg <= 1'b0;
      issued_reg  <= 1'b0;
      have_reg    <= 1'b0;
      data_reg    <= '0;
    end else begin
      if (launch) begin
        q_valid_reg <= 1'b1;
      end else if (grant) begin
        q_valid_reg <= 1'b0;
      end

      if (clear) begin
        issued_reg <= 1'b0;
        have_reg   <= 1'b0;
      end else begin
        if (grant) begin
          issued_reg <= 1'b1;
        end
        if (capture) begin
          have_reg <= 1'b1;
        end
      end

      if (capture) begin
        data_reg <= p_data;
      end
    end
  end

  assign q_valid  = q_valid_reg;
  // Counting a same-cycle capture lets the tile complete without an extra cycle.
  assign complete = have_reg | capture;
  assign data     = data_reg;

endmodule

// File: rtl/snax_gemm_tcdm_reader.sv
// GEMM operand fetch: reads one A tile and one B tile over NumPorts TCDM ports
// per step, presents them with valid/ready and walks k_tiles_i tiles by stride.
module snax_gemm_tcdm_reader
  import snax_gemm_pkg::*;
#(
  parameter int unsigned NumPorts   = 16,
  parameter int unsigned DataWidth  = 64,
  parameter int unsigned AddrWidth  = 17,
  parameter int unsigned CntWidth   = 16,
  parameter type         tcdm_req_t = snax_gemm_pkg::tcdm_req_t,
  parameter type         tcdm_rsp_t = snax_gemm_pkg::tcdm_rsp_t
) (
  input  logic                                clk_i,
  input  logic                                rst_ni,
  input  logic                                start_i,
  input  logic [AddrWidth-1:0]                base_a_i,
  input  logic [AddrWidth-1:0]                base_b_i,
  input  logic [AddrWidth-1:0]                stride_a_i,
  input  logic [AddrWidth-1:0]                stride_b_i,
  input  logic [CntWidth-1:0]                 k_tiles_i,
  output logic                                busy_o,
  output logic                                done_o,
  output logic [NumPorts/2*DataWidth-1:0]     a_o,
  output logic [NumPorts/2*DataWidth-1:0]     b_o,
  output logic                                valid_o,
  input  logic                                ready_i,
  output tcdm_req_t                           tcdm_req_o [NumPorts],
  input  tcdm_rsp_t                           tcdm_rsp_i [NumPorts]
);

  localparam int unsigned Half       = NumPorts / 2;
  localparam int unsigned ByteOffset = byte_offset(DataWidth);

  reader_state_e        state_reg;
  logic [CntWidth-1:0]  tile_reg;
  logic [CntWidth-1:0]  k_reg;
  logic [AddrWidth-1:0] addr_a_reg;
  logic [AddrWidth-1:0] addr_b_reg;
  logic [AddrWidth-1:0] stride_a_reg;
  logic [AddrWidth-1:0] stride_b_reg;
  logic                 done_empty_reg;

  logic                 accept;
  logic                 transfer;
  logic                 last_tile;
  logic                 launch;
  logic                 all_complete;

  logic [NumPorts-1:0]  slot_q_valid;
  logic [NumPorts-1:0]  slot_complete;
  logic [DataWidth-1:0] slot_data [NumPorts];

  assign accept       = (state_reg == IDLE) & start_i;
  assign transfer     = (state_reg == OUT) & ready_i;
  assign last_tile    = (tile_reg == (k_reg - CntWidth'(1)));
  assign launch       = (accept & (k_tiles_i != '0)) | (transfer & ~last_tile);
  assign all_complete = &slot_complete;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg      <= IDLE;
      tile_reg       <= '0;
      k_reg          <= '0;
      addr_a_reg     <= '0;
      addr_b_reg     <= '0;
      stride_a_reg   <= '0;
      stride_b_reg   <= '0;
      done_empty_reg <= 1'b0;
    end else begin
      done_empty_reg <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (start_i) begin
            addr_a_reg   <= base_a_i;
            addr_b_reg   <= base_b_i;
            stride_a_reg <= stride_a_i;
            stride_b_reg <= stride_b_i;
            k_reg        <= k_tiles_i;
            tile_reg     <= '0;
            if (k_tiles_i == '0) begin
              done_empty_reg <= 1'b1;
            end else begin
              state_reg <= FETCH;
            end
          end
        end
        FETCH: begin
          if (all_complete) begin
            state_reg <= OUT;
          end
        end
        OUT: begin
          if (ready_i) begin
            tile_reg   <= tile_reg + CntWidth'(1);
            addr_a_reg <= addr_a_reg + stride_a_reg;
            addr_b_reg <= addr_b_reg + stride_b_reg;
            state_reg  <= last_tile ? IDLE : FETCH;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign busy_o  = (state_reg != IDLE);
  assign valid_o = (state_reg == OUT);
  assign done_o  = done_empty_reg | (transfer & last_tile);

  genvar gi;
  generate
    for (gi = 0; gi < NumPorts; gi++) begin : g_port
      // Offsets wrap modulo 2^AddrWidth together with the base address.
      localparam logic [AddrWidth-1:0] PortOffset = AddrWidth'((gi % Half) * ByteOffset);

      logic [AddrWidth-1:0] port_base;
      tcdm_req_t            req;

      if (gi < Half) begin : g_a
        assign port_base = addr_a_reg;
      end else begin : g_b
        assign port_base = addr_b_reg;
      end

      snax_gemm_port_slot #(
        .DataWidth(DataWidth)
      ) i_slot (
        .clk_i   (clk_i),
        .rst_ni  (rst_ni),
        .launch  (launch),
        .clear   (transfer),
        .q_ready (tcdm_rsp_i[gi].q_ready),
        .p_valid (tcdm_rsp_i[gi].p_valid),
        .p_data  (tcdm_rsp_i[gi].p.data),
        .q_valid (slot_q_valid[gi]),
        .complete(slot_complete[gi]),
        .data    (slot_data[gi])
      );

      always_comb begin
        req         = '0;
        req.q_valid = slot_q_valid[gi];
        req.q.addr  = port_base + PortOffset;
        req.q.strb  = '1;
      end

      assign tcdm_req_o[gi] = req;
    end

    for (gi = 0; gi < Half; gi++) begin : g_pack
      assign a_o[gi*DataWidth +: DataWidth] = slot_data[gi];
      assign b_o[gi*DataWidth +: DataWidth] = slot_data[Half + gi];
    end
  endgenerate

endmodule
